// File: rtl/rf_pkg.sv
// Shared constants and helpers for the rename register file.
package rf_pkg;

  localparam int ZERO_REG   = 0;
  localparam int MAX_COMMIT = 4;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Low bit of lane k in a packed multi-port bus of lane width w.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: x0 override and optional commit bypass.
// Bypass is compiled in with RF_COMMIT_BYPASS_EN.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_WIDTH = 4,
  parameter int AW        = 5,
  parameter int CW        = 2
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [XLEN-1:0]      value_i,
  input  logic                 busy_i,
  input  logic [ROB_WIDTH-1:0] tag_i,
  input  logic [CW-1:0]        apply_i,
  input  logic [CW*AW-1:0]     byp_addr_i,
  input  logic [CW*XLEN-1:0]   byp_value_i,
  output logic [XLEN-1:0]      value_o,
  output logic [ROB_WIDTH-1:0] rename_o,
  output logic                 valid_o
);

  logic            is_zero;
  logic            hit;
  logic [XLEN-1:0] hit_val;

`ifdef RF_COMMIT_BYPASS_EN
  always_comb begin
    hit     = 1'b0;
    hit_val = value_i;
    // Ascending scan so the highest matching port wins.
    for (int k = 0; k < CW; k++) begin
      if (apply_i[k] &&
          byp_addr_i[slice_lo(k, AW) +: AW] == addr_i) begin
        hit     = 1'b1;
        hit_val = byp_value_i[slice_lo(k, XLEN) +: XLEN];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^{apply_i, byp_addr_i, byp_value_i};
  assign hit        = 1'b0;
  assign hit_val    = value_i;
`endif

  assign is_zero  = (addr_i == AW'(ZERO_REG));
  assign value_o  = is_zero ? '0 : hit_val;
  assign rename_o = is_zero ? '0 : tag_i;
  assign valid_o  = is_zero | ~busy_i | hit;

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with rename tags and multi-port commit.
// Optional same-cycle commit bypass: RF_COMMIT_BYPASS_EN.
module rename_register_file
  import rf_pkg::*;
#(
  parameter int ROB_WIDTH    = 4,
  parameter int XLEN         = 32,
  parameter int REG_COUNT    = 32,
  parameter int COMMIT_WIDTH = 2,
  localparam int REG_ADDR_W  = addr_w(REG_COUNT)
) (
  input  logic                               clockIn,
  input  logic                               resetIn,
  input  logic                               readyIn,
  input  logic                               clearIn,
  input  logic                               rdFlag,
  input  logic [REG_ADDR_W-1:0]              rdAddr,
  input  logic [ROB_WIDTH-1:0]               rdDest,
  input  logic [REG_ADDR_W-1:0]              rs1Addr,
  input  logic [REG_ADDR_W-1:0]              rs2Addr,
  output logic [XLEN-1:0]                    rs1Value,
  output logic [XLEN-1:0]                    rs2Value,
  output logic [ROB_WIDTH-1:0]               rs1Rename,
  output logic [ROB_WIDTH-1:0]               rs2Rename,
  output logic                               rs1Valid,
  output logic                               rs2Valid,
  input  logic [COMMIT_WIDTH-1:0]            commitFlag,
  input  logic [COMMIT_WIDTH*ROB_WIDTH-1:0]  commitRobId,
  input  logic [COMMIT_WIDTH*REG_ADDR_W-1:0] commitAddr,
  input  logic [COMMIT_WIDTH*XLEN-1:0]       commitValue
);

  localparam logic [REG_ADDR_W-1:0] X0 = REG_ADDR_W'(ZERO_REG);

  logic [XLEN-1:0]      value_q [REG_COUNT];
  logic [XLEN-1:0]      value_d [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  logic [REG_ADDR_W-1:0] c_addr [COMMIT_WIDTH];
  logic [ROB_WIDTH-1:0]  c_tag  [COMMIT_WIDTH];
  logic [XLEN-1:0]       c_val  [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] apply;
  logic                    do_rename;

  // Tag match uses start-of-cycle tags, so renames cannot kill a commit.
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      c_addr[k] = commitAddr[slice_lo(k, REG_ADDR_W) +: REG_ADDR_W];
      c_tag[k]  = commitRobId[slice_lo(k, ROB_WIDTH) +: ROB_WIDTH];
      c_val[k]  = commitValue[slice_lo(k, XLEN) +: XLEN];
      apply[k]  = readyIn && commitFlag[k] &&
                  (c_addr[k] != X0) &&
                  (tag_q[c_addr[k]] == c_tag[k]);
    end
  end

  assign do_rename = readyIn && !clearIn && rdFlag && (rdAddr != X0);

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (apply[k]) begin
        value_d[c_addr[k]] = c_val[k];
        busy_d[c_addr[k]]  = 1'b0;
      end
    end
    if (readyIn && clearIn) begin
      busy_d = '0;
    end
    if (do_rename) begin
      busy_d[rdAddr] = 1'b1;
      tag_d[rdAddr]  = rdDest;
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else if (readyIn) begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  rf_read_port #(
    .XLEN      (XLEN),
    .ROB_WIDTH (ROB_WIDTH),
    .AW        (REG_ADDR_W),
    .CW        (COMMIT_WIDTH)
  ) u_rs1 (
    .addr_i      (rs1Addr),
    .value_i     (value_q[rs1Addr]),
    .busy_i      (busy_q[rs1Addr]),
    .tag_i       (tag_q[rs1Addr]),
    .apply_i     (apply),
    .byp_addr_i  (commitAddr),
    .byp_value_i (commitValue),
    .value_o     (rs1Value),
    .rename_o    (rs1Rename),
    .valid_o     (rs1Valid)
  );

  rf_read_port #(
    .XLEN      (XLEN),
    .ROB_WIDTH (ROB_WIDTH),
    .AW        (REG_ADDR_W),
    .CW        (COMMIT_WIDTH)
  ) u_rs2 (
    .addr_i      (rs2Addr),
    .value_i     (value_q[rs2Addr]),
    .busy_i      (busy_q[rs2Addr]),
    .tag_i       (tag_q[rs2Addr]),
    .apply_i     (apply),
    .byp_addr_i  (commitAddr),
    .byp_value_i (commitValue),
    .value_o     (rs2Value),
    .rename_o    (rs2Rename),
    .valid_o     (rs2Valid)
  );

endmodule
